// File: rtl/block_movement_to_motor_pkg.sv
// Shared board geometry, cell/col/row types, FSM state codes and the cell-index decoder.
package block_movement_pkg;
  localparam int COLS  = 4;
  localparam int ROWS  = 5;
  localparam int CELLS = COLS * ROWS;

  typedef logic [4:0] cell_t;
  typedef logic [1:0] col_t;
  typedef logic [2:0] row_t;

  typedef struct packed {
    row_t row;
    col_t col;
  } colrow_t;

  localparam cell_t LAST_CELL = cell_t'(CELLS - 1);

  typedef logic [3:0] state_t;
  localparam state_t ST_IDLE    = 4'd0;
  localparam state_t ST_SEEK_X  = 4'd1;
  localparam state_t ST_SEEK_Y  = 4'd2;
  localparam state_t ST_MAG_ON  = 4'd3;
  localparam state_t ST_DRAG_X  = 4'd4;
  localparam state_t ST_DRAG_Y  = 4'd5;
  localparam state_t ST_MAG_OFF = 4'd6;
  localparam state_t ST_HOME_X  = 4'd7;
  localparam state_t ST_HOME_Y  = 4'd8;
  localparam state_t ST_DONE    = 4'd9;

  function automatic colrow_t idx_to_colrow(cell_t idx);
    colrow_t cr;
    cr.col = col_t'(idx % cell_t'(COLS));
    cr.row = row_t'(idx / cell_t'(COLS));
    return cr;
  endfunction
endpackage

// File: rtl/block_movement_to_motor_if.sv
// Command strobe/indices from the move sequencer plus the stepper, magnet and done pins.
interface block_movement_to_motor_if;
  import block_movement_pkg::*;

  logic  i_en;
  cell_t i_Start_Block;
  cell_t i_End_Block;
  logic  o_step_control_x;
  logic  o_direction_x;
  logic  o_step_control_y;
  logic  o_direction_y;
  logic  o_magnet;
  logic  o_done;

  modport master (
    output i_en, i_Start_Block, i_End_Block,
    input  o_step_control_x, o_direction_x, o_step_control_y, o_direction_y, o_magnet, o_done
  );

  modport slave (
    input  i_en, i_Start_Block, i_End_Block,
    output o_step_control_x, o_direction_x, o_step_control_y, o_direction_y, o_magnet, o_done
  );
endinterface

// File: rtl/block_movement_to_motor_axis_stepper.sv
// One axis: on start emits |delta|*STEPS_PER_CELL pulses (half low, half high); done_o flags the last cycle.
module axis_stepper
  import block_movement_pkg::*;
#(
  parameter int STEPS_PER_CELL   = 200,
  parameter int STEP_HALF_CYCLES = 25000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic signed [3:0] delta_i,
  output logic              step_o,
  output logic              dir_o,
  output logic              done_o
);
  localparam int CNT_W  = $clog2((ROWS - 1) * STEPS_PER_CELL + 1);
  localparam int HALF_W = (STEP_HALF_CYCLES > 1) ? $clog2(STEP_HALF_CYCLES) : 1;
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(STEP_HALF_CYCLES - 1);

  logic              busy_q, step_q, dir_q;
  logic [HALF_W-1:0] half_q;
  logic [CNT_W-1:0]  steps_q;
  logic [CNT_W-1:0]  total_steps;
  logic [3:0]        mag;
  logic              half_end;

  assign mag         = delta_i[3] ? -delta_i : delta_i;
  assign total_steps = CNT_W'(32'(mag) * 32'(STEPS_PER_CELL));
  assign half_end    = (half_q == HALF_LAST);

  // Zero delta finishes in the start cycle; otherwise done marks the final high half-period.
  assign done_o = (start_i && (delta_i == 4'sd0)) ||
                  (busy_q && step_q && half_end && (steps_q == CNT_W'(1)));
  assign step_o = step_q;
  assign dir_o  = dir_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q  <= 1'b0;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      half_q  <= '0;
      steps_q <= '0;
    end else if (start_i && (delta_i != 4'sd0)) begin
      busy_q  <= 1'b1;
      step_q  <= 1'b0;
      half_q  <= '0;
      steps_q <= total_steps;
      dir_q   <= ~delta_i[3];
    end else if (busy_q && half_end) begin
      half_q <= '0;
      step_q <= ~step_q;
      if (step_q) begin
        steps_q <= steps_q - CNT_W'(1);
        busy_q  <= (steps_q != CNT_W'(1));
      end
    end else if (busy_q) begin
      half_q <= half_q + HALF_W'(1);
    end
  end
endmodule

// File: rtl/block_movement_to_motor.sv
// Klotski block mover: seek to start cell magnet-off, drag to end cell magnet-on, release, pulse done.
// Define BM2M_RETURN_HOME_EN to add a magnet-off return to cell 0 before done.
module block_movement_to_motor
  import block_movement_pkg::*;
#(
  parameter int STEPS_PER_CELL       = 200,
  parameter int STEP_HALF_CYCLES     = 25000,
  parameter int MAGNET_SETTLE_CYCLES = 500000
) (
  input logic                      i_Clk,
  input logic                      i_rst,
  block_movement_to_motor_if.slave mv
);
  localparam int SETTLE_W = (MAGNET_SETTLE_CYCLES > 1) ? $clog2(MAGNET_SETTLE_CYCLES) : 1;

  state_t              state_q, state_d;
  logic                entry_q;
  col_t                cur_col_q, cur_col_d, tgt_col;
  row_t                cur_row_q, cur_row_d, tgt_row;
  colrow_t             src_q, dst_q;
  logic [SETTLE_W-1:0] settle_q;
  logic signed [3:0]   dx, dy;
  logic                x_start, y_start, x_done, y_done, settled;

  always_comb begin
    tgt_col = '0;
    tgt_row = '0;
    case (state_q)
      ST_SEEK_X, ST_SEEK_Y: begin tgt_col = src_q.col; tgt_row = src_q.row; end
      ST_DRAG_X, ST_DRAG_Y: begin tgt_col = dst_q.col; tgt_row = dst_q.row; end
      default: ;
    endcase
  end

  assign dx      = $signed({2'b00, tgt_col}) - $signed({2'b00, cur_col_q});
  assign dy      = $signed({1'b0, tgt_row}) - $signed({1'b0, cur_row_q});
  // Steppers are kicked only in the first cycle of each segment state.
  assign x_start = entry_q && (state_q == ST_SEEK_X || state_q == ST_DRAG_X || state_q == ST_HOME_X);
  assign y_start = entry_q && (state_q == ST_SEEK_Y || state_q == ST_DRAG_Y || state_q == ST_HOME_Y);
  assign settled = (settle_q == SETTLE_W'(MAGNET_SETTLE_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    cur_col_d = cur_col_q;
    cur_row_d = cur_row_q;
    case (state_q)
      ST_IDLE:
        if (mv.i_en)
          state_d = (mv.i_Start_Block > LAST_CELL || mv.i_End_Block > LAST_CELL) ? ST_DONE : ST_SEEK_X;
      ST_SEEK_X: if (x_done) begin state_d = ST_SEEK_Y; cur_col_d = tgt_col; end
      ST_SEEK_Y: if (y_done) begin state_d = ST_MAG_ON; cur_row_d = tgt_row; end
      ST_MAG_ON: if (settled) state_d = ST_DRAG_X;
      ST_DRAG_X: if (x_done) begin state_d = ST_DRAG_Y; cur_col_d = tgt_col; end
      ST_DRAG_Y: if (y_done) begin state_d = ST_MAG_OFF; cur_row_d = tgt_row; end
`ifdef BM2M_RETURN_HOME_EN
      ST_MAG_OFF: if (settled) state_d = ST_HOME_X;
      ST_HOME_X: if (x_done) begin state_d = ST_HOME_Y; cur_col_d = tgt_col; end
      ST_HOME_Y: if (y_done) begin state_d = ST_DONE; cur_row_d = tgt_row; end
`else
      ST_MAG_OFF: if (settled) state_d = ST_DONE;
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      entry_q   <= 1'b0;
      cur_col_q <= '0;
      cur_row_q <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      settle_q  <= '0;
    end else begin
      state_q   <= state_d;
      entry_q   <= (state_d != state_q);
      cur_col_q <= cur_col_d;
      cur_row_q <= cur_row_d;
      if (state_q == ST_IDLE && mv.i_en) begin
        src_q <= idx_to_colrow(mv.i_Start_Block);
        dst_q <= idx_to_colrow(mv.i_End_Block);
      end
      settle_q <= ((state_q == ST_MAG_ON || state_q == ST_MAG_OFF) && !settled) ?
                  settle_q + SETTLE_W'(1) : '0;
    end
  end

  assign mv.o_magnet = (state_q == ST_MAG_ON) || (state_q == ST_DRAG_X) || (state_q == ST_DRAG_Y);
  assign mv.o_done   = (state_q == ST_DONE);

  axis_stepper #(.STEPS_PER_CELL(STEPS_PER_CELL), .STEP_HALF_CYCLES(STEP_HALF_CYCLES)) u_x (
    .clk_i(i_Clk), .rst_i(i_rst), .start_i(x_start), .delta_i(dx),
    .step_o(mv.o_step_control_x), .dir_o(mv.o_direction_x), .done_o(x_done)
  );

  axis_stepper #(.STEPS_PER_CELL(STEPS_PER_CELL), .STEP_HALF_CYCLES(STEP_HALF_CYCLES)) u_y (
    .clk_i(i_Clk), .rst_i(i_rst), .start_i(y_start), .delta_i(dy),
    .step_o(mv.o_step_control_y), .dir_o(mv.o_direction_y), .done_o(y_done)
  );
endmodule

// File: tb/tb_block_movement_to_motor.sv
// Scoreboard bench: a position model predicts per-phase pulse counts/directions for each command.
module tb_block_movement_to_motor;
  localparam int SPC = 2;

  typedef struct {
    int n [2][2];
    bit d [2][2];
    int mag;
    bit invalid;
    int issue;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   exp_dones = 0;
  int   pos_c = 0;
  int   pos_r = 0;

  exp_t exp_q[$];
  exp_t e;
  int   cnt [3][2];
  bit   seen0 [3][2];
  bit   seen1 [3][2];
  int   mag_rises;
  bit   mag_seen, overlap, prev_x, prev_y, prev_mag, done_prev;
  int   ph;

  block_movement_to_motor_if mv();

  block_movement_to_motor #(
    .STEPS_PER_CELL(SPC), .STEP_HALF_CYCLES(2), .MAGNET_SETTLE_CYCLES(4)
  ) dut (
    .i_Clk(clk), .i_rst(rst), .mv(mv)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic clear_mon();
    for (int p = 0; p < 3; p++)
      for (int a = 0; a < 2; a++) begin
        cnt[p][a] = 0; seen0[p][a] = 0; seen1[p][a] = 0;
      end
    mag_rises = 0; mag_seen = 0; overlap = 0;
  endtask

  task automatic record(input int p, input int a, input bit dir);
    cnt[p][a]++;
    if (dir) seen1[p][a] = 1; else seen0[p][a] = 1;
  endtask

  // Monitor: buckets pulses into seek (before magnet), drag (magnet on), post (after release).
  always @(negedge clk) begin
    if (rst) begin
      clear_mon();
      prev_x = 0; prev_y = 0; prev_mag = 0; done_prev = 0;
    end else begin
      if (done_prev) check_eq("done_one_cycle", mv.o_done, 0);
      if (mv.o_step_control_x && mv.o_step_control_y) overlap = 1;
      ph = mv.o_magnet ? 1 : (mag_seen ? 2 : 0);
      if (mv.o_step_control_x && !prev_x) record(ph, 0, mv.o_direction_x);
      if (mv.o_step_control_y && !prev_y) record(ph, 1, mv.o_direction_y);
      if (mv.o_magnet && !prev_mag) begin mag_rises++; mag_seen = 1; end
      if (mv.o_done && !done_prev) begin
        done_cnt++;
        check_eq("done_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          for (int p = 0; p < 2; p++)
            for (int a = 0; a < 2; a++) begin
              check_eq($sformatf("pulses_%s_%s", p ? "drag" : "seek", a ? "y" : "x"), cnt[p][a], e.n[p][a]);
              if (e.n[p][a] > 0)
                check_eq($sformatf("wrong_dir_%s_%s", p ? "drag" : "seek", a ? "y" : "x"),
                         e.d[p][a] ? seen0[p][a] : seen1[p][a], 0);
            end
          check_eq("post_release_pulses", cnt[2][0] + cnt[2][1], 0);
          check_eq("magnet_rises", mag_rises, e.mag);
          check_eq("step_overlap", overlap, 0);
          check_eq("magnet_at_done", mv.o_magnet, 0);
          if (e.invalid) check_eq("invalid_latency_le3", (cyc - e.issue) <= 3, 1);
        end
        clear_mon();
      end
      prev_x = mv.o_step_control_x; prev_y = mv.o_step_control_y;
      prev_mag = mv.o_magnet; done_prev = mv.o_done;
    end
  end

  task automatic send_cmd(input int s, input int t, input bit poke);
    exp_t x;
    int sc, sr, ec, er;
    bit got;
    for (int p = 0; p < 2; p++)
      for (int a = 0; a < 2; a++) begin x.n[p][a] = 0; x.d[p][a] = 0; end
    x.mag = 0;
    x.issue = cyc;
    x.invalid = (s > 19) || (t > 19);
    if (!x.invalid) begin
      sc = s % 4; sr = s / 4; ec = t % 4; er = t / 4;
      x.n[0][0] = iabs(sc - pos_c) * SPC; x.d[0][0] = sc > pos_c;
      x.n[0][1] = iabs(sr - pos_r) * SPC; x.d[0][1] = sr > pos_r;
      x.n[1][0] = iabs(ec - sc) * SPC;    x.d[1][0] = ec > sc;
      x.n[1][1] = iabs(er - sr) * SPC;    x.d[1][1] = er > sr;
      x.mag = 1;
      pos_c = ec; pos_r = er;
    end
    exp_q.push_back(x);
    exp_dones++;
    mv.i_en = 1'b1; mv.i_Start_Block = 5'(s); mv.i_End_Block = 5'(t);
    @(negedge clk);
    mv.i_en = 1'b0;
    got = 0;
    for (int k = 0; k < 3000; k++) begin
      if (mv.o_done) begin got = 1; break; end
      mv.i_en = poke && (k == 6);
      if (poke && k == 6) begin mv.i_Start_Block = 5'd0; mv.i_End_Block = 5'd19; end
      @(negedge clk);
    end
    check_eq("done_seen", got, 1);
    // Strobe during the DONE cycle must be ignored.
    mv.i_en = 1'b1; mv.i_Start_Block = 5'd0; mv.i_End_Block = 5'd1;
    @(negedge clk);
    mv.i_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bit found;
    mv.i_en = 1'b0; mv.i_Start_Block = '0; mv.i_End_Block = '0;
    clear_mon();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_step_x", mv.o_step_control_x, 0);
    check_eq("rst_dir_x", mv.o_direction_x, 0);
    check_eq("rst_step_y", mv.o_step_control_y, 0);
    check_eq("rst_dir_y", mv.o_direction_y, 0);
    check_eq("rst_magnet", mv.o_magnet, 0);
    check_eq("rst_done", mv.o_done, 0);

    send_cmd(0, 1, 0);
    send_cmd(6, 10, 0);
    send_cmd(7, 6, 0);
    send_cmd(5, 5, 1);
    send_cmd(20, 3, 0);
    send_cmd(3, 31, 0);

    // Interrupt a 5->19 move in DRAG_X with reset.
    mv.i_en = 1'b1; mv.i_Start_Block = 5'd5; mv.i_End_Block = 5'd19;
    @(negedge clk);
    mv.i_en = 1'b0;
    found = 0;
    for (int k = 0; k < 2000; k++) begin
      if (mv.o_magnet && mv.o_step_control_x) begin found = 1; break; end
      @(negedge clk);
    end
    check_eq("reached_drag_x", found, 1);
    check_eq("drag_x_dir_before_rst", mv.o_direction_x, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_step_x", mv.o_step_control_x, 0);
    check_eq("midrst_dir_x", mv.o_direction_x, 0);
    check_eq("midrst_step_y", mv.o_step_control_y, 0);
    check_eq("midrst_dir_y", mv.o_direction_y, 0);
    check_eq("midrst_magnet", mv.o_magnet, 0);
    check_eq("midrst_done", mv.o_done, 0);
    @(negedge clk);
    rst = 1'b0;
    pos_c = 0; pos_r = 0;
    @(negedge clk);

    send_cmd(0, 1, 0);
    repeat (20) @(negedge clk);
    check_eq("done_count", done_cnt, exp_dones);
    check_eq("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
